sdp_ram_be: RTL

//  Parametrised simple-dual-port RAM, one clock: independent write port (byte enables) and read port.

---
 rtl/sdp_ram_be_if.sv | 30 +++
 rtl/sdp_ram_be.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be_if.sv
// Write/read bus of the simple-dual-port RAM.
// The master drives requests; the slave returns read data, valid and busy.
interface sdp_ram_be_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_W-1:0]       wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle registered read,
// selectable read-during-write and an optional post-reset clear engine.
module sdp_ram_be #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DEPTH          = 12,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  sdp_ram_be_if.slave bus
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("sdp_ram_be: RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $error("sdp_ram_be: DEPTH out of range");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy;
  logic                  clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end
      end
      S_IDLE: ;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      S_IDLE: ;
    endcase
  end

  logic                  wr_in, rd_in;
  logic                  wr_ok, rd_ok, fwd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign wr_in = 32'(bus.wr_addr) < DEPTH;
  assign rd_in = 32'(bus.rd_addr) < DEPTH;
  assign wr_ok = bus.wr_en & ~busy & wr_in;
  assign rd_ok = bus.rd_en & ~busy;
  assign fwd   = (RDW_MODE != 0) && wr_ok &&
                 (bus.wr_addr == bus.rd_addr);

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) begin
          mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem_q[bus.rd_addr];
      // Write-first: splice the enabled bytes of the concurrent write.
      if (fwd) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) begin
            rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  logic                  v1_q;
  logic [DATA_WIDTH-1:0] d1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_ok;
      if (rd_ok) begin
        d1_q <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign bus.rd_valid = v2_q;
    assign bus.rd_data  = d2_q;
  end else begin : g_lat1
    assign bus.rd_valid = v1_q;
    assign bus.rd_data  = d1_q;
  end

  assign bus.busy = busy;
endmodule
